// File: rtl/float_pkg.sv
// Shared definitions for the compact float word {sign, exp, sig} and its decoder FSM.
package float_pkg;
  localparam int EXP_W = 3;
  localparam int SIG_W = 4;
  localparam int OUT_W = 12;
  localparam int FLT_W = 1 + EXP_W + SIG_W;

  // Field offsets inside the packed float word, shared with the extractor side
  localparam int SIG_LSB  = 0;
  localparam int EXP_LSB  = SIG_W;
  localparam int SIGN_POS = SIG_W + EXP_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIX   = 2'd2,
    DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/float_to_twos.sv
// Expands one {sign, exp, sig} float per transaction into an OUT_W two's-complement
// word using a one-bit-per-cycle shift datapath; one transaction in flight.
module float_to_twos
  import float_pkg::*;
#(
  parameter int EXP_W_P = EXP_W,
  parameter int SIG_W_P = SIG_W,
  parameter int OUT_W_P = OUT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sign,
  input  logic [EXP_W_P-1:0] in_exp,
  input  logic [SIG_W_P-1:0] in_sig,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [OUT_W_P-1:0] out_data
);

  state_e               state_q, state_d;
  logic [OUT_W_P-1:0]   mag_q, mag_d;
  logic [EXP_W_P-1:0]   cnt_q, cnt_d;
  logic                 sgn_q, sgn_d;
  logic [OUT_W_P-1:0]   out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;

  assign in_ready  = (state_q == IDLE) & ~rst;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      cnt_q       <= '0;
      sgn_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      sgn_q       <= sgn_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    cnt_d       = cnt_q;
    sgn_d       = sgn_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          mag_d   = OUT_W_P'(in_sig);
          cnt_d   = in_exp;
          sgn_d   = in_sign;
          // A zero shift count goes straight to the negate stage
          state_d = (in_exp != '0) ? SHIFT : FIX;
        end
      end
      SHIFT: begin
        mag_d = mag_q << 1;
        cnt_d = cnt_q - EXP_W_P'(1);
        if (cnt_q == EXP_W_P'(1)) state_d = FIX;
      end
      FIX: begin
        out_data_d  = sgn_q ? (~mag_q + OUT_W_P'(1)) : mag_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
